// File: rtl/rv_bus_responder_if.sv
// Bus-unit connection between the core's bus unit (master) and a memory responder (slave).
// Handshake: the master pulses ads for one cycle with the request fields valid in that
// cycle; the slave answers with exactly one ack cycle carrying rd_data/bus_err. There is
// no backpressure: a new ads is only legal while busy is low or in the ack cycle itself.
interface rv_bus_responder_if;
  logic        ads;
  logic        rd_wr_n;
  logic        i_dn;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ack;
  logic        bus_err;
  logic        proto_err;
  logic        busy;

  modport master (
    output ads, rd_wr_n, i_dn, addr, be, wr_data,
    input  rd_data, ack, bus_err, proto_err, busy
  );

  modport slave (
    input  ads, rd_wr_n, i_dn, addr, be, wr_data,
    output rd_data, ack, bus_err, proto_err, busy
  );
endinterface

// File: rtl/rv_bus_responder.sv
// Target-side memory responder for the bus unit: latches an ads request, waits I_WAIT or
// D_WAIT cycles, then acks once with word read data or a byte-enabled write commit.
module rv_bus_responder #(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          I_WAIT      = 0,
   parameter int          D_WAIT      = 1
) (
   input  logic                clk,
   input  logic                reset_n,
   rv_bus_responder_if.slave   bus,
   output logic [1:0]          dbg_state
);

   localparam int          IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;
   localparam logic [3:0]  I_W   = 4'(I_WAIT);
   localparam logic [3:0]  D_W   = 4'(D_WAIT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic       accept, proto_hit;

   logic             lat_rd, lat_in_range;
   logic [IDX_W-1:0] lat_idx;
   logic [3:0]       lat_be;
   logic [31:0]      lat_wdata;

   logic [31:0] rd_data_q;
   logic        bus_err_q, proto_err_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic [31:0]      bus_off;
   logic             bus_in_range;
   logic [IDX_W-1:0] bus_idx;
   logic [3:0]       w_sel;

   logic             req_rd, req_in_range;
   logic [IDX_W-1:0] req_idx;
   logic             commit, enter_ack;
   logic [31:0]      rd_word;

   // Offset wraps modulo 2^32, so addresses below BASE_ADDR land out of range.
   assign bus_off      = bus.addr - BASE_ADDR;
   assign bus_in_range = ({1'b0, bus_off} < LIMIT);
   assign bus_idx      = bus_off[IDX_W+1:2];
   assign w_sel        = bus.i_dn ? I_W : D_W;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      proto_hit = 1'b0;
      case (state)
         S_IDLE, S_ACK: begin
            state_nxt = S_IDLE;
            if (bus.ads) begin
               accept    = 1'b1;
               cnt_nxt   = w_sel;
               state_nxt = (w_sel == 4'd0) ? S_ACK : S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_nxt = cnt - 4'd1;
            if (cnt == 4'd1) state_nxt = S_ACK;
            if (bus.ads) proto_hit = 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // A request accepted this cycle uses the live bus fields; otherwise the latched ones.
   // A write committing on this same edge is forwarded so back-to-back reads see it.
   always_comb begin
      req_rd       = accept ? bus.rd_wr_n : lat_rd;
      req_in_range = accept ? bus_in_range : lat_in_range;
      req_idx      = accept ? bus_idx : lat_idx;
      commit       = (state == S_ACK) && !lat_rd && lat_in_range;
      enter_ack    = (state_nxt == S_ACK);
      rd_word      = mem[req_idx];
      if (commit && (lat_idx == req_idx)) begin
         for (int i = 0; i < 4; i++) begin
            if (lat_be[i]) rd_word[8*i +: 8] = lat_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= S_IDLE;
         cnt          <= 4'd0;
         lat_rd       <= 1'b0;
         lat_in_range <= 1'b0;
         lat_idx      <= '0;
         lat_be       <= 4'd0;
         lat_wdata    <= 32'd0;
         rd_data_q    <= 32'd0;
         bus_err_q    <= 1'b0;
         proto_err_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            lat_rd       <= bus.rd_wr_n;
            lat_in_range <= bus_in_range;
            lat_idx      <= bus_idx;
            lat_be       <= bus.be;
            lat_wdata    <= bus.wr_data;
         end
         if (proto_hit) proto_err_q <= 1'b1;
         bus_err_q <= enter_ack && !req_in_range;
         if (enter_ack && req_rd) rd_data_q <= req_in_range ? rd_word : 32'd0;
      end
   end

   // Array has no reset; commit is gated by state, which reset forces to IDLE.
   always_ff @(posedge clk) begin
      if (commit) begin
         for (int i = 0; i < 4; i++) begin
            if (lat_be[i]) mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
         end
      end
   end

   assign bus.ack       = (state == S_ACK);
   assign bus.busy      = (state != S_IDLE);
   assign bus.rd_data   = rd_data_q;
   assign bus.bus_err   = bus_err_q;
   assign bus.proto_err = proto_err_q;
   assign dbg_state     = state;

endmodule

// File: tb/tb_rv_bus_responder.sv
// Directed bench for rv_bus_responder with I_WAIT=0, D_WAIT=3, 1024 words at base 0.
module tb_rv_bus_responder;
  localparam int IW = 0;
  localparam int DW = 3;

  logic clk;
  logic reset_n;
  logic [1:0] dbg_state;
  int checks;
  int failures;

  rv_bus_responder_if bus_if ();

  rv_bus_responder #(
    .DEPTH_WORDS(1024),
    .BASE_ADDR  (32'h0000_0000),
    .I_WAIT     (IW),
    .D_WAIT     (DW)
  ) u_dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus_if),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one ads cycle starting now; returns #1 into the cycle after ads.
  task automatic issue(input logic rd, input logic inst, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
    bus_if.ads     = 1'b1;
    bus_if.rd_wr_n = rd;
    bus_if.i_dn    = inst;
    bus_if.addr    = a;
    bus_if.be      = b;
    bus_if.wr_data = d;
    step();
    bus_if.ads     = 1'b0;
    bus_if.addr    = 32'hxxxx_xxxx;
    bus_if.wr_data = 32'hxxxx_xxxx;
  endtask

  // Called in the cycle after ads; ends inside the ack cycle.
  task automatic expect_ack(input string tag, input int w, input logic [31:0] exp_rd,
                            input logic exp_err);
    for (int k = 1; k <= w + 1; k++) begin
      if (k > 1) step();
      check({tag, ".busy"}, 32'(bus_if.busy), 32'd1);
      check({tag, ".ack"}, 32'(bus_if.ack), (k == w + 1) ? 32'd1 : 32'd0);
    end
    check({tag, ".rd_data"}, bus_if.rd_data, exp_rd);
    check({tag, ".bus_err"}, 32'(bus_if.bus_err), 32'(exp_err));
  endtask

  task automatic expect_idle(input string tag);
    step();
    check({tag, ".ack_low"}, 32'(bus_if.ack), 32'd0);
    check({tag, ".busy_low"}, 32'(bus_if.busy), 32'd0);
    check({tag, ".err_low"}, 32'(bus_if.bus_err), 32'd0);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    reset_n        = 1'b0;
    bus_if.ads     = 1'b0;
    bus_if.rd_wr_n = 1'b1;
    bus_if.i_dn    = 1'b0;
    bus_if.addr    = 32'd0;
    bus_if.be      = 4'd0;
    bus_if.wr_data = 32'd0;
    repeat (3) step();

    // reset state
    check("rst.ack", 32'(bus_if.ack), 32'd0);
    check("rst.busy", 32'(bus_if.busy), 32'd0);
    check("rst.rd_data", bus_if.rd_data, 32'd0);
    check("rst.bus_err", 32'(bus_if.bus_err), 32'd0);
    check("rst.proto_err", 32'(bus_if.proto_err), 32'd0);
    check("rst.state", 32'(dbg_state), 32'd0);
    reset_n = 1'b1;
    step();

    // 1: data write then read, W=3
    issue(1'b0, 1'b0, 32'h10, 4'hF, 32'hCAFE_F00D);
    expect_ack("t1.wr", DW, 32'h0, 1'b0);
    expect_idle("t1.wr");
    issue(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
    expect_ack("t1.rd", DW, 32'hCAFE_F00D, 1'b0);
    expect_idle("t1.rd");
    check("t1.rd_hold", bus_if.rd_data, 32'hCAFE_F00D);

    // 2: byte enables
    issue(1'b0, 1'b0, 32'h20, 4'hF, 32'h1122_3344);
    expect_ack("t2.wr0", DW, 32'hCAFE_F00D, 1'b0);
    step();
    issue(1'b0, 1'b0, 32'h20, 4'b0101, 32'hAABB_CCDD);
    expect_ack("t2.wr1", DW, 32'hCAFE_F00D, 1'b0);
    step();
    issue(1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    expect_ack("t2.rd1", DW, 32'h11BB_33DD, 1'b0);
    step();
    issue(1'b0, 1'b0, 32'h20, 4'b0000, 32'hFFFF_FFFF);
    expect_ack("t2.wr_be0", DW, 32'h11BB_33DD, 1'b0);
    step();
    issue(1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    expect_ack("t2.rd2", DW, 32'h11BB_33DD, 1'b0);
    step();

    // 3: instruction fetch with zero wait; low address bits ignored
    issue(1'b1, 1'b1, 32'h13, 4'h0, 32'h0);
    expect_ack("t3.fetch", IW, 32'hCAFE_F00D, 1'b0);
    expect_idle("t3.fetch");
    issue(1'b0, 1'b1, 32'h30, 4'hF, 32'h5A5A_5A5A);
    expect_ack("t3.iwr", IW, 32'hCAFE_F00D, 1'b0);
    step();
    issue(1'b1, 1'b0, 32'h30, 4'h0, 32'h0);
    expect_ack("t3.rd", DW, 32'h5A5A_5A5A, 1'b0);
    step();

    // 4: range boundary
    issue(1'b0, 1'b0, 32'h0, 4'hF, 32'h0123_4567);
    expect_ack("t4.wr0", DW, 32'h5A5A_5A5A, 1'b0);
    step();
    issue(1'b0, 1'b0, 32'hFFC, 4'hF, 32'hDEAD_BEEF);
    expect_ack("t4.wr_last", DW, 32'h5A5A_5A5A, 1'b0);
    step();
    issue(1'b1, 1'b0, 32'hFFC, 4'h0, 32'h0);
    expect_ack("t4.rd_last", DW, 32'hDEAD_BEEF, 1'b0);
    step();
    issue(1'b1, 1'b0, 32'h1000, 4'h0, 32'h0);
    expect_ack("t4.rd_oor", DW, 32'h0, 1'b1);
    expect_idle("t4.rd_oor");
    issue(1'b0, 1'b0, 32'h1000, 4'hF, 32'hFFFF_FFFF);
    expect_ack("t4.wr_oor", DW, 32'h0, 1'b1);
    step();
    issue(1'b1, 1'b0, 32'h0, 4'h0, 32'h0);
    expect_ack("t4.rd0", DW, 32'h0123_4567, 1'b0);
    step();

    // 5a: ads during WAIT is ignored and flags proto_err
    issue(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    step();
    issue(1'b0, 1'b0, 32'h10, 4'hF, 32'h0000_0000);
    check("t5.proto_set", 32'(bus_if.proto_err), 32'd1);
    check("t5.ack_t3", 32'(bus_if.ack), 32'd0);
    step();
    check("t5.ack_t4", 32'(bus_if.ack), 32'd1);
    check("t5.rd_data", bus_if.rd_data, 32'hCAFE_F00D);
    expect_idle("t5.single_ack");
    check("t5.proto_sticky", 32'(bus_if.proto_err), 32'd1);
    issue(1'b1, 1'b1, 32'h10, 4'h0, 32'h0);
    expect_ack("t5.not_written", IW, 32'hCAFE_F00D, 1'b0);
    step();

    // 5b: back-to-back ads in the ack cycle, including read-after-write forwarding
    issue(1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    expect_ack("t5.b2b_first", DW, 32'h11BB_33DD, 1'b0);
    issue(1'b0, 1'b1, 32'h40, 4'hF, 32'h1357_9BDF);
    expect_ack("t5.b2b_wr", IW, 32'h11BB_33DD, 1'b0);
    issue(1'b1, 1'b1, 32'h40, 4'h0, 32'h0);
    expect_ack("t5.raw", IW, 32'h1357_9BDF, 1'b0);
    issue(1'b1, 1'b0, 32'h30, 4'h0, 32'h0);
    expect_ack("t5.b2b_data", DW, 32'h5A5A_5A5A, 1'b0);
    step();

    // 6: reset during WAIT aborts the write
    issue(1'b0, 1'b0, 32'h10, 4'hF, 32'h0BAD_0BAD);
    step();
    reset_n = 1'b0;
    #1;
    check("t6.rst_ack", 32'(bus_if.ack), 32'd0);
    check("t6.rst_busy", 32'(bus_if.busy), 32'd0);
    check("t6.rst_rd_data", bus_if.rd_data, 32'd0);
    check("t6.rst_bus_err", 32'(bus_if.bus_err), 32'd0);
    check("t6.rst_proto", 32'(bus_if.proto_err), 32'd0);
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("t6.no_ack", 32'(bus_if.ack), 32'd0);
    end
    issue(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    expect_ack("t6.unchanged", DW, 32'hCAFE_F00D, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
